// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver feeding the receive FIFO.
//
// The asynchronous serial line is synchronized, then a frame FSM finds the
// start bit, samples every bit at mid-bit, checks the optional parity bit and
// the stop bit. A good frame is delivered on Rx_Data with a one-cycle
// Data_Rdy strobe. BIST_Mode parks the receiver in IDLE.
//
// Parameters:
//   DATA_BITS    data bits per frame (5..9), LSB first
//   CLKS_PER_BIT clock cycles per bit (even, >= 4)
//   PARITY_EN    1: a parity bit follows the data bits
//   PARITY_ODD   1: odd parity, 0: even parity
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   Rx           asynchronous serial input, idles high
//   BIST_Mode    1: hold receiver in IDLE
//   Rx_Data      data of the last good frame
//   Data_Rdy     one-cycle strobe, Rx_Data is new
//   Parity_Err   parity mismatch on the last delivered frame
//   Framing_Err  stop bit of the last frame sampled low
//   Busy         receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Rx,
    input  logic                 BIST_Mode,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Data_Rdy,
    output logic                 Parity_Err,
    output logic                 Framing_Err,
    output logic                 Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    localparam logic PAR_EN  = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t               state_q;
    logic                 rx_meta_q;
    logic                 rx_sync_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_mis_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 data_rdy_q;
    logic                 parity_err_q;
    logic                 framing_err_q;
    logic                 busy_q;

    // Parity bit a correct transmitter would send for this data word.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] data);
        return (^data) ^ PAR_ODD;
    endfunction

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM with bit timing, data capture and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= CNT_ZERO;
            idx_q         <= IDX_ZERO;
            shift_q       <= {DATA_BITS{1'b0}};
            par_mis_q     <= 1'b0;
            rx_data_q     <= {DATA_BITS{1'b0}};
            data_rdy_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            data_rdy_q <= 1'b0;
            if (BIST_Mode) begin
                // Abort any frame; only Busy reflects the change.
                state_q <= S_IDLE;
                cnt_q   <= CNT_ZERO;
                idx_q   <= IDX_ZERO;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_sync_q) begin
                            state_q <= S_START;
                            cnt_q   <= CNT_ZERO;
                            busy_q  <= 1'b1;
                        end else begin
                            busy_q  <= 1'b0;
                        end
                    end
                    S_START: begin
                        if (cnt_q == CNT_HALF) begin
                            if (!rx_sync_q) begin
                                state_q   <= S_DATA;
                                cnt_q     <= CNT_ZERO;
                                idx_q     <= IDX_ZERO;
                                par_mis_q <= 1'b0;
                            end else begin
                                // Start bit gone by mid-bit: treat as glitch.
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_DATA: begin
                        if (cnt_q == CNT_LAST) begin
                            // LSB-first: after DATA_BITS shifts, bit 0 sits at [0].
                            shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
                            cnt_q   <= CNT_ZERO;
                            idx_q   <= idx_q + IDX_ONE;
                            if (idx_q == IDX_LAST) begin
                                state_q <= PAR_EN ? S_PARITY : S_STOP;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_PARITY: begin
                        if (cnt_q == CNT_LAST) begin
                            par_mis_q <= rx_sync_q ^ expected_parity(shift_q);
                            cnt_q     <= CNT_ZERO;
                            state_q   <= S_STOP;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_STOP: begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q <= CNT_ZERO;
                            if (rx_sync_q) begin
                                rx_data_q     <= shift_q;
                                data_rdy_q    <= 1'b1;
                                parity_err_q  <= par_mis_q;
                                framing_err_q <= 1'b0;
                                state_q       <= S_IDLE;
                                busy_q        <= 1'b0;
                            end else begin
                                // Bad stop: flag it and wait out a possible break.
                                parity_err_q  <= 1'b0;
                                framing_err_q <= 1'b1;
                                state_q       <= S_WAIT_IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (rx_sync_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_WAIT_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        cnt_q   <= CNT_ZERO;
                        idx_q   <= IDX_ZERO;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Rx_Data     = rx_data_q;
    assign Data_Rdy    = data_rdy_q;
    assign Parity_Err  = parity_err_q;
    assign Framing_Err = framing_err_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- scoreboard bench for uart_rx.
// Instance A: 8N1, 16 clocks/bit. Instance B: 8E1 (even parity).
// Stimulus pushes the expected delivered word into a per-instance queue;
// monitors pop and compare whenever Data_Rdy is seen.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    typedef struct {
        logic [7:0] d;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic       bist_a = 1'b0;
    logic [7:0] data_a, data_b;
    logic       rdy_a, rdy_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   rdy_cnt_a = 0, rdy_cnt_b = 0;
    int   rdy_cyc_a = 0, rdy_prev_cyc_a = 0;

    uart_rx u_dut_a (
        .clk(clk), .rst_n(rst_n), .Rx(rx_a), .BIST_Mode(bist_a),
        .Rx_Data(data_a), .Data_Rdy(rdy_a), .Parity_Err(perr_a),
        .Framing_Err(ferr_a), .Busy(busy_a)
    );

    uart_rx #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .Rx(rx_b), .BIST_Mode(1'b0),
        .Rx_Data(data_b), .Data_Rdy(rdy_b), .Parity_Err(perr_b),
        .Framing_Err(ferr_b), .Busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: even parity bit makes the total count of ones even.
    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic drive_bit(input int which, input logic v, input int ncyc);
        if (which == 0) rx_a = v;
        else            rx_b = v;
        repeat (ncyc) @(negedge clk);
    endtask

    // Whole frame at exact rate; line is left at the stop-bit level.
    task automatic send(input int which, input logic [7:0] d, input logic par, input logic stop);
        drive_bit(which, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], 16);
        if (which == 1) drive_bit(which, par, 16);
        drive_bit(which, stop, 16);
    endtask

    // Frame on instance A with an arbitrary bit length in ns (baud offset).
    task automatic send_ns(input logic [7:0] d, input int bit_ns);
        rx_a = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            rx_a = d[i];
            #(bit_ns);
        end
        rx_a = 1'b1;
        #(bit_ns);
        @(negedge clk);
    endtask

    task automatic push_a(input logic [7:0] d);
        exp_t e;
        e.d = d;
        e.perr = 1'b0;
        q_a.push_back(e);
    endtask

    task automatic push_b(input logic [7:0] d, input logic par);
        exp_t e;
        e.d = d;
        e.perr = (par != even_par(d));
        q_b.push_back(e);
    endtask

    // Monitor A
    initial begin
        exp_t e;
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rdy_a) begin
                chk("a_rdy_not_consecutive", {31'd0, prev}, 32'd0);
                if (q_a.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL a_unexpected_rdy actual=%0h required=none", data_a);
                end else begin
                    e = q_a.pop_front();
                    chk("a_data", data_a, e.d);
                    chk("a_perr", perr_a, e.perr);
                    chk("a_ferr", ferr_a, 32'd0);
                end
                rdy_cnt_a++;
                rdy_prev_cyc_a = rdy_cyc_a;
                rdy_cyc_a = cyc;
            end
            prev = rdy_a;
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rdy_b) begin
                if (q_b.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL b_unexpected_rdy actual=%0h required=none", data_b);
                end else begin
                    e = q_b.pop_front();
                    chk("b_data", data_b, e.d);
                    chk("b_perr", perr_b, e.perr);
                    chk("b_ferr", ferr_b, 32'd0);
                end
                rdy_cnt_b++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int n0;
        logic [7:0] d;
        logic p;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", data_a, 32'd0);
        chk("rst_rdy", rdy_a, 32'd0);
        chk("rst_flags", {perr_a, ferr_a, perr_b, ferr_b}, 32'd0);
        chk("rst_busy", {busy_a, busy_b}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Clean frame 0xA5: strobe at T0+152, T0 three clocks after the fall
        push_a(8'hA5);
        c0 = cyc;
        fork
            send(0, 8'hA5, 1'b0, 1'b1);
            begin
                repeat (2) @(negedge clk);
                chk("clean_busy_pre_t0", busy_a, 32'd0);
                repeat (1) @(negedge clk);
                chk("clean_busy_at_t0", busy_a, 32'd1);
                repeat (151) @(negedge clk);
                chk("clean_busy_before_stop", busy_a, 32'd1);
                repeat (1) @(negedge clk);
                chk("clean_busy_fall", busy_a, 32'd0);
            end
        join
        chk("clean_rdy_time", rdy_cyc_a - c0, 32'd155);
        repeat (10) @(negedge clk);
        chk("clean_rdy_count", rdy_cnt_a, 32'd1);

        // Glitch rejection: 4-clock low pulse
        n0 = rdy_cnt_a;
        c0 = cyc;
        rx_a = 1'b0;
        repeat (4) @(negedge clk);
        rx_a = 1'b1;
        repeat (6) @(negedge clk);
        chk("glitch_busy_last", busy_a, 32'd1);
        repeat (1) @(negedge clk);
        chk("glitch_busy_drop", busy_a, 32'd0);
        repeat (200) @(negedge clk);
        chk("glitch_no_rdy", rdy_cnt_a - n0, 32'd0);
        chk("glitch_data_kept", data_a, 32'hA5);

        // Framing error with a held-low line
        n0 = rdy_cnt_a;
        send(0, 8'h3C, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        chk("frm_ferr", ferr_a, 32'd1);
        chk("frm_perr", perr_a, 32'd0);
        chk("frm_busy_held", busy_a, 32'd1);
        chk("frm_no_rdy", rdy_cnt_a - n0, 32'd0);
        chk("frm_data_kept", data_a, 32'hA5);
        rx_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("frm_busy_until_rxs", busy_a, 32'd1);
        repeat (2) @(negedge clk);
        chk("frm_busy_drop", busy_a, 32'd0);
        repeat (30) @(negedge clk);
        push_a(8'h55);
        send(0, 8'h55, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("frm_cleared", ferr_a, 32'd0);

        // Parity error on instance B, then a good parity frame
        push_b(8'h01, 1'b0);
        send(1, 8'h01, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("par_err_set", perr_b, 32'd1);
        chk("par_data", data_b, 32'h01);
        push_b(8'h03, 1'b0);
        send(1, 8'h03, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        chk("par_err_clear", perr_b, 32'd0);
        chk("par_rdy_count", rdy_cnt_b, 32'd2);

        // Reset during data bit 3 of 0xF0
        repeat (20) @(negedge clk);
        n0 = rdy_cnt_a;
        fork
            send(0, 8'hF0, 1'b0, 1'b1);
            begin
                repeat (76) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("mid_rst_data", data_a, 32'd0);
                chk("mid_rst_outs", {rdy_a, perr_a, ferr_a, busy_a}, 32'd0);
                rst_n = 1'b1;
            end
        join
        repeat (30) @(negedge clk);
        chk("mid_rst_no_rdy", rdy_cnt_a - n0, 32'd0);
        push_a(8'h0F);
        send(0, 8'h0F, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("mid_rst_recover", data_a, 32'h0F);

        // Back-to-back frames, no gap
        repeat (20) @(negedge clk);
        push_a(8'h00);
        push_a(8'hFF);
        send(0, 8'h00, 1'b0, 1'b1);
        send(0, 8'hFF, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        chk("b2b_spacing", rdy_cyc_a - rdy_prev_cyc_a, 32'd160);
        chk("b2b_last", data_a, 32'hFF);

        // Back-to-back again, BIST raised during the second frame
        repeat (20) @(negedge clk);
        n0 = rdy_cnt_a;
        push_a(8'h00);
        fork
            begin
                send(0, 8'h00, 1'b0, 1'b1);
                send(0, 8'hFF, 1'b0, 1'b1);
            end
            begin
                repeat (200) @(negedge clk);
                chk("bist_busy_before", busy_a, 32'd1);
                bist_a = 1'b1;
                @(negedge clk);
                chk("bist_busy_drop", busy_a, 32'd0);
                repeat (114) @(negedge clk);
                bist_a = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        chk("bist_one_frame", rdy_cnt_a - n0, 32'd1);
        chk("bist_data", data_a, 32'h00);
        chk("bist_flags", {perr_a, ferr_a, busy_a}, 32'd0);

        // Randomized frames at exact rate with random idle gaps
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            push_a(d);
            send(0, d, 1'b0, 1'b1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        // +3 % and -3 % bit periods
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            push_a(d);
            send_ns(d, (i % 2 == 0) ? 165 : 155);
            repeat ($urandom_range(0, 10)) @(negedge clk);
        end

        // Randomized parity frames on B, some with a wrong parity bit
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            p = even_par(d) ^ ($urandom_range(0, 3) == 0);
            push_b(d, p);
            send(1, d, p, 1'b1);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        repeat (40) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
